// File: rtl/int_alu_pkg.sv
// Shared types and defaults for the sequential integer ALU blocks.
// Holds the controller state encoding and the default operand/chunk widths.
package int_alu_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_CHUNK_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Width of a counter that walks n chunks; never narrower than one bit.
  function automatic int chunk_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_sub_chunk.sv
// Combinational WIDTH-bit subtract slice with borrow in/out.
// The borrow is the sign bit of a one-bit-wider difference.
module int_sub_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] wide_diff;

  always_comb begin
    wide_diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};
    diff       = wide_diff[WIDTH-1:0];
    borrow_out = wide_diff[WIDTH];
  end

endmodule

// File: rtl/int_sub_seq.sv
// Multi-cycle subtractor: one CHUNK_WIDTH slice per enabled cycle, LSB chunk first.
// Results are published only on the final chunk, so outputs stay stable during CALC.
module int_sub_seq
  import int_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  borrow_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out,
  output logic                  overflow
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W = chunk_idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [DATA_WIDTH-1:0]   diff_acc;
  logic                    borrow_reg;

  logic [DATA_WIDTH-1:0]   diff_full;
  logic [CHUNK_WIDTH-1:0]  a_chunk;
  logic [CHUNK_WIDTH-1:0]  b_chunk;
  logic [CHUNK_WIDTH-1:0]  chunk_diff;
  logic                    chunk_borrow;
  logic                    last_chunk;
  logic                    overflow_full;
  int                      base;

  // diff_full merges the chunk being computed now into the partial result,
  // so the final edge can publish the complete difference directly.
  always_comb begin
    base       = int'(idx) * CHUNK_WIDTH;
    a_chunk    = a_reg[base +: CHUNK_WIDTH];
    b_chunk    = b_reg[base +: CHUNK_WIDTH];
    diff_full  = diff_acc;
    diff_full[base +: CHUNK_WIDTH] = chunk_diff;
    last_chunk = (idx == LAST_IDX);
    overflow_full = (a_reg[DATA_WIDTH-1] ^ b_reg[DATA_WIDTH-1]) &
                    (diff_full[DATA_WIDTH-1] ^ a_reg[DATA_WIDTH-1]);
  end

  int_sub_chunk #(
    .WIDTH (CHUNK_WIDTH)
  ) u_chunk (
    .a          (a_chunk),
    .b          (b_chunk),
    .borrow_in  (borrow_reg),
    .diff       (chunk_diff),
    .borrow_out (chunk_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      diff_acc   <= '0;
      borrow_reg <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg      <= data_a;
            b_reg      <= data_b;
            borrow_reg <= borrow_in;
            diff_acc   <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          diff_acc   <= diff_full;
          borrow_reg <= chunk_borrow;
          if (last_chunk) begin
            idx        <= '0;
            diff       <= diff_full;
            borrow_out <= chunk_borrow;
            overflow   <= overflow_full;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
